universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register, the next generation of the single-bit D flip-flop storage cells. It holds a WIDTH-bit word and executes commands through a valid/ready interface: parallel load, clear, and multi-cycle logical, rotate and arithmetic shifts of a programmable bit count. Each command reports completion with a one-cycle done pulse. It sits between datapath producers and serial or bit-manipulating consumers.

## Interface
Parameters:
- WIDTH, 8: register width in bits (≥2)
- AMT_W, 4: width of the shift-amount field

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR
- cmd_amt  in  AMT_W  shift count, used by shift ops only
- d  in  WIDTH  parallel load data
- sin  in  1  serial input for SHL/SHR, sampled live on every shift edge
- q  out  WIDTH  register contents
- qnot  out  WIDTH  ~q; present only with USR_QNOT_EN
- sout  out  1  last bit shifted or rotated out, registered
- done  out  1  one-cycle pulse when a command completes

## Operation
- FSM states: IDLE and SHIFT. cmd_ready = (state == IDLE). A command is accepted on an edge where cmd_valid && cmd_ready.
- HOLD: q unchanged.
- LOAD: q ← d.
- CLR: q ← 0, sout ← 0.
- All three take effect on the accept edge. The FSM stays in IDLE.
- Shift ops with cmd_amt = k ≥ 1: the accept edge latches op and counter = k, and the FSM enters SHIFT. Each SHIFT edge performs one 1-bit step and decrements the counter. The step at counter == 1 returns the FSM to IDLE.
- Shift ops with cmd_amt = 0: treated as HOLD (single-cycle, q unchanged, done pulses).
- Step definitions:
  - SHL: q ← {q[W-2:0], sin}, sout ← q[W-1]
  - SHR: q ← {sin, q[W-1:1]}, sout ← q[0]
  - ROL: q ← {q[W-2:0], q[W-1]}, sout ← q[W-1]
  - ROR: q ← {q[0], q[W-1:1]}, sout ← q[0]
  - ASR: q ← {q[W-1], q[W-1:1]}, sout ← q[0]
- k > WIDTH is legal; the block keeps stepping (rotates wrap, logical shifts saturate to sin fill).
- cmd_valid while in SHIFT is ignored: no queueing, no effect on the command in flight.
- d, cmd_op and cmd_amt are sampled only on the accept edge.

## Timing
- Reset values: q = 0, qnot = all ones, sout = 0, done = 0, state IDLE, cmd_ready = 1.
- Single-cycle ops: result visible in q after the accept edge E0. done is high in the cycle after E0. cmd_ready stays high, so back-to-back commands are accepted every cycle.
- Shift k: steps occur at edges E1..Ek. cmd_ready is low from after E0 through Ek and high again after Ek. done is registered at Ek (high for the cycle after Ek). Total latency is k+1 edges.
- rst mid-SHIFT: at that edge q = 0, sout = 0, state IDLE, and the counter is cleared. No done pulse is issued for the aborted command. rst has priority over a simultaneous accept.

## Configuration
- USR_QNOT_EN defined: qnot port exists, driven combinationally as ~q.
- USR_QNOT_EN undefined: qnot port and its logic are absent. All other behaviour is identical.

## Structure
- Package usr_pkg holds:
  - usr_op_e: 3-bit opcode enum with the encodings above
  - usr_state_e: IDLE/SHIFT
  - constant USR_OP_W = 3
- Sub-module usr_shift_step: combinational single-bit step. Inputs are q, op and sin; outputs are next q and the out-bit. The top level instantiates it once and owns the FSM, counter and registers.

## Test plan
1. rst high 2 cycles → q = 0x00, qnot = 0xFF, sout = 0, done = 0, cmd_ready = 1.
2. LOAD d = 0xA5, then LOAD d = 0x3C on the next cycle → q = 0xA5 then 0x3C; done high two consecutive cycles; cmd_ready never drops.
3. From 0xA5, SHL k = 3, sin = 1 → q steps 0x4B, 0x97, 0x2F; sout = 1; cmd_ready low 3 cycles; single done after E3.
4. From 0xA5, ROR k = 4 → q steps 0xD2, 0x69, 0xB4, 0x5A; sout = 0. Pulse cmd_valid with LOAD mid-shift → ignored, final q = 0x5A.
5. LOAD 0x80, then ASR k = 2 → q = 0xE0. SHR with k = 0 → q unchanged, done after one cycle.
6. From 0xFF, SHR k = 8, sin = 0; assert rst after the 3rd step → q = 0x00, cmd_ready = 1 next cycle, no done pulse.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: opcode and FSM state encodings.
package usr_pkg;

    localparam int USR_OP_W = 3;

    typedef enum logic [USR_OP_W-1:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6,
        OP_CLR  = 3'd7
    } usr_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit shift/rotate step; non-shift opcodes pass q through.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  usr_op_e          op_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             out_bit_o
);

    always_comb begin
        q_o       = q_i;
        out_bit_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                q_o       = {q_i[WIDTH-2:0], sin_i};
                out_bit_o = q_i[WIDTH-1];
            end
            OP_SHR: begin
                q_o       = {sin_i, q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            OP_ROL: begin
                q_o       = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                out_bit_o = q_i[WIDTH-1];
            end
            OP_ROR: begin
                q_o       = {q_i[0], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            OP_ASR: begin
                q_o       = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                out_bit_o = q_i[0];
            end
            default: begin
                q_o       = q_i;
                out_bit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with valid/ready command port and multi-cycle shifts.
// Optional macro USR_QNOT_EN adds the qnot (~q) output port.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    // Handshake: a command is taken on any rising edge where cmd_valid && cmd_ready;
    // cmd_valid during a shift is ignored, nothing is queued.
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [USR_OP_W-1:0] cmd_op,
    input  logic [AMT_W-1:0]    cmd_amt,
    input  logic [WIDTH-1:0]    d,
    input  logic                sin,
    output logic [WIDTH-1:0]    q,
    output logic                sout,
    output logic                done
`ifdef USR_QNOT_EN
    ,
    output logic [WIDTH-1:0]    qnot
`endif
);

    usr_state_e       state_q, state_d;
    usr_op_e          op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    usr_op_e          cmd_op_e;

    assign cmd_op_e = usr_op_e'(cmd_op);

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i       (q_q),
        .op_i      (op_q),
        .sin_i     (sin),
        .q_o       (step_q),
        .out_bit_o (step_bit)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op_e)
                        OP_HOLD: done_d = 1'b1;
                        OP_LOAD: begin
                            q_d    = d;
                            done_d = 1'b1;
                        end
                        OP_CLR: begin
                            q_d    = '0;
                            sout_d = 1'b0;
                            done_d = 1'b1;
                        end
                        default: begin
                            // A zero-length shift completes immediately like HOLD.
                            if (cmd_amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                op_d    = cmd_op_e;
                                cnt_d   = cmd_amt;
                                state_d = ST_SHIFT;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                q_d    = step_q;
                sout_d = step_bit;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign q         = q_q;
    assign sout      = sout_q;
    assign done      = done_q;
`ifdef USR_QNOT_EN
    assign qnot      = ~q_q;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed scenarios plus randomized shifts.
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int AW = 4;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
    localparam logic [2:0] ROL  = 3'd4, ROR  = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'd0;
    logic [AW-1:0] cmd_amt = '0;
    logic [W-1:0]  d = '0;
    logic          sin = 1'b0;
    logic [W-1:0]  q;
    logic          sout;
    logic          done;
`ifdef USR_QNOT_EN
    logic [W-1:0]  qnot;
`endif

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    universal_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .d         (d),
        .sin       (sin),
        .q         (q),
        .sout      (sout),
        .done      (done)
`ifdef USR_QNOT_EN
        ,
        .qnot      (qnot)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference step: returns {out_bit, next_q}
    function automatic logic [W:0] step_model(input logic [2:0] op, input logic [W-1:0] v, input logic s);
        case (op)
            SHL:     step_model = {v[W-1], v[W-2:0], s};
            SHR:     step_model = {v[0], s, v[W-1:1]};
            ROL:     step_model = {v[W-1], v[W-2:0], v[W-1]};
            ROR:     step_model = {v[0], v[0], v[W-1:1]};
            ASR:     step_model = {v[0], v[W-1], v[W-1:1]};
            default: step_model = {1'b0, v};
        endcase
    endfunction

    task automatic load_word(input logic [W-1:0] v);
        logic [W-1:0] e;
        cmd_valid = 1'b1; cmd_op = LOAD; d = v;
        exp_q.push_back(v);
        tick;
        cmd_valid = 1'b0;
        e = exp_q.pop_front();
        checks++; if (q !== e) begin failures++; $display("FAIL load_q got=%h exp=%h", q, e); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL load_done got=%b exp=1", done); end
    endtask

    // Runs a shift whose per-step q values were pushed by the caller.
    task automatic shift_run(input logic [2:0] op, input logic [AW-1:0] amt, input logic s,
                             input logic sout_exp, input bit poke);
        logic [W-1:0] e;
        int n;
        sin = s; cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt;
        tick;
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL shift_busy got=%b exp=0", cmd_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL shift_e0_done got=%b exp=0", done); end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (poke && i == 1) begin
                cmd_valid = 1'b1; cmd_op = LOAD; d = 8'h00;
            end
            tick;
            cmd_valid = 1'b0;
            e = exp_q.pop_front();
            checks++; if (q !== e) begin failures++; $display("FAIL shift_step%0d_q got=%h exp=%h", i, q, e); end
            checks++; if (cmd_ready !== (i == n - 1)) begin failures++; $display("FAIL shift_step%0d_ready got=%b exp=%b", i, cmd_ready, (i == n - 1)); end
            checks++; if (done !== (i == n - 1)) begin failures++; $display("FAIL shift_step%0d_done got=%b exp=%b", i, done, (i == n - 1)); end
        end
        checks++; if (sout !== sout_exp) begin failures++; $display("FAIL shift_sout got=%b exp=%b", sout, sout_exp); end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0;
        tick; tick;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL rst_q got=%h exp=00", q); end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL rst_sout got=%b exp=0", sout); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
`ifdef USR_QNOT_EN
        checks++; if (qnot !== 8'hFF) begin failures++; $display("FAIL rst_qnot got=%h exp=ff", qnot); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] e;
        cmd_valid = 1'b1; cmd_op = LOAD;
        d = 8'hA5; exp_q.push_back(8'hA5);
        tick;
        e = exp_q.pop_front();
        checks++; if (q !== e) begin failures++; $display("FAIL b2b_q0 got=%h exp=%h", q, e); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done0 got=%b exp=1", done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", cmd_ready); end
        d = 8'h3C; exp_q.push_back(8'h3C);
        tick;
        cmd_valid = 1'b0;
        e = exp_q.pop_front();
        checks++; if (q !== e) begin failures++; $display("FAIL b2b_q1 got=%h exp=%h", q, e); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", cmd_ready); end
`ifdef USR_QNOT_EN
        checks++; if (qnot !== 8'hC3) begin failures++; $display("FAIL b2b_qnot got=%h exp=c3", qnot); end
`endif
        tick;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    endtask

    task automatic test_shl;
        load_word(8'hA5);
        exp_q.push_back(8'h4B); exp_q.push_back(8'h97); exp_q.push_back(8'h2F);
        shift_run(SHL, 4'd3, 1'b1, 1'b1, 1'b0);
        tick;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL shl_single_done got=%b exp=0", done); end
    endtask

    task automatic test_ror_ignore;
        load_word(8'hA5);
        exp_q.push_back(8'hD2); exp_q.push_back(8'h69); exp_q.push_back(8'hB4); exp_q.push_back(8'h5A);
        shift_run(ROR, 4'd4, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_asr_zero;
        load_word(8'h80);
        exp_q.push_back(8'hC0); exp_q.push_back(8'hE0);
        shift_run(ASR, 4'd2, 1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_op = SHR; cmd_amt = 4'd0; sin = 1'b1;
        tick;
        cmd_valid = 1'b0;
        checks++; if (q !== 8'hE0) begin failures++; $display("FAIL zero_q got=%h exp=e0", q); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_clr_hold;
        load_word(8'h81);
        exp_q.push_back(8'h03);
        shift_run(ROL, 4'd1, 1'b0, 1'b1, 1'b0);
        cmd_valid = 1'b1; cmd_op = CLR;
        tick;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL clr_q got=%h exp=00", q); end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL clr_sout got=%b exp=0", sout); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL clr_done got=%b exp=1", done); end
        cmd_valid = 1'b0;
        load_word(8'h3C);
        cmd_valid = 1'b1; cmd_op = HOLD; d = 8'hFF;
        tick;
        cmd_valid = 1'b0;
        checks++; if (q !== 8'h3C) begin failures++; $display("FAIL hold_q got=%h exp=3c", q); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", done); end
    endtask

    task automatic test_rst_mid;
        logic [W-1:0] e;
        load_word(8'hFF);
        sin = 1'b0; cmd_valid = 1'b1; cmd_op = SHR; cmd_amt = 4'd8;
        tick;
        cmd_valid = 1'b0;
        exp_q.push_back(8'h7F); exp_q.push_back(8'h3F); exp_q.push_back(8'h1F);
        for (int i = 0; i < 3; i++) begin
            tick;
            e = exp_q.pop_front();
            checks++; if (q !== e) begin failures++; $display("FAIL rstmid_step%0d_q got=%h exp=%h", i, q, e); end
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL rstmid_q got=%h exp=00", q); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done); end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL rstmid_sout got=%b exp=0", sout); end
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++; if (done !== 1'b0 || q !== 8'h00) begin failures++; $display("FAIL rstmid_after%0d done=%b q=%h exp done=0 q=00", i, done, q); end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] m, e;
        logic         ms, s;
        logic [W:0]   r;
        logic [2:0]   op;
        int           amt;
        for (int it = 0; it < 24; it++) begin
            m = W'($urandom_range(0, 255));
            load_word(m);
            op  = 3'($urandom_range(2, 6));
            amt = $urandom_range(1, 15);
            ms  = sout;
            cmd_valid = 1'b1; cmd_op = op; cmd_amt = AW'(amt); d = ~m;
            tick;
            cmd_valid = 1'b0;
            for (int i = 0; i < amt; i++) begin
                s = 1'($urandom_range(0, 1));
                sin = s;
                r = step_model(op, m, s);
                ms = r[W];
                m  = r[W-1:0];
                exp_q.push_back(m);
                tick;
                e = exp_q.pop_front();
                checks++; if (q !== e) begin failures++; $display("FAIL rand%0d_op%0d_step%0d_q got=%h exp=%h", it, op, i, q, e); end
            end
            checks++; if (sout !== ms) begin failures++; $display("FAIL rand%0d_sout got=%b exp=%b", it, sout, ms); end
            checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rand%0d_end done=%b ready=%b exp 1 1", it, done, cmd_ready); end
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_shl;
        test_ror_ignore;
        test_asr_zero;
        test_clr_hold;
        test_rst_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
